// File: rtl/fft_stream_checker.sv
// Golden-stream checker for one-sample-per-clock FFT/IFFT cores: reads expected samples from a
// synchronous memory, compares them to the DUT stream with a per-component tolerance, and counts errors.
module fft_stream_checker #(
  parameter int unsigned DW      = 24,
  parameter int unsigned N       = 1024,
  parameter int unsigned AW      = $clog2(N),
  parameter int unsigned LATENCY = 19,
  parameter int unsigned TOL     = 0,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          cont,
  input  logic [DW-1:0] dut_out,
  output logic          exp_rd,
  output logic [AW-1:0] exp_addr,
  input  logic [DW-1:0] exp_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic [AW-1:0] first_err_idx,
  output logic [CW-1:0] first_err_frame,
  output logic          first_err_valid,
  output logic [CW-1:0] frame_cnt
);

  localparam int unsigned H  = DW / 2;
  localparam int unsigned LW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StCheck} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] wait_cnt_q, wait_cnt_d;
  logic          cont_lat_q, cont_lat_d;
  logic          exp_rd_q, exp_rd_d;
  logic [AW-1:0] exp_addr_q, exp_addr_d;
  logic          cmp_vld_q, cmp_vld_d;
  logic [AW-1:0] cmp_idx_q, cmp_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [CW-1:0] err_count_q, err_count_d;
  logic [AW-1:0] first_err_idx_q, first_err_idx_d;
  logic [CW-1:0] first_err_frame_q, first_err_frame_d;
  logic          first_err_valid_q, first_err_valid_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;

  // One extra bit keeps the difference of two H-bit signed values exact.
  function automatic logic comp_bad(input logic [H-1:0] a, input logic [H-1:0] b);
    logic signed [H:0] diff;
    logic [H:0]        mag;
    diff = $signed({a[H-1], a}) - $signed({b[H-1], b});
    mag  = diff[H] ? (~diff + 1'b1) : diff;
    return 64'(mag) > 64'(TOL);
  endfunction

  logic mismatch;
  assign mismatch = comp_bad(dut_out[DW-1:H], exp_data[DW-1:H]) ||
                    comp_bad(dut_out[H-1:0], exp_data[H-1:0]);

  always_comb begin
    state_d           = state_q;
    wait_cnt_d        = wait_cnt_q;
    cont_lat_d        = cont_lat_q;
    exp_rd_d          = exp_rd_q;
    exp_addr_d        = exp_addr_q;
    cmp_vld_d         = 1'b0;
    cmp_idx_d         = cmp_idx_q;
    busy_d            = busy_q;
    done_d            = 1'b0;
    pass_d            = pass_q;
    err_count_d       = err_count_q;
    first_err_idx_d   = first_err_idx_q;
    first_err_frame_d = first_err_frame_q;
    first_err_valid_d = first_err_valid_q;
    frame_cnt_d       = frame_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d           = (LATENCY == 2) ? StCheck : StWait;
          wait_cnt_d        = LW'(LATENCY - 2);
          cont_lat_d        = cont;
          exp_rd_d          = (LATENCY == 2);
          exp_addr_d        = '0;
          busy_d            = 1'b1;
          pass_d            = 1'b0;
          err_count_d       = '0;
          first_err_idx_d   = '0;
          first_err_frame_d = '0;
          first_err_valid_d = 1'b0;
          frame_cnt_d       = '0;
        end
      end
      StWait: begin
        if (wait_cnt_q == LW'(1)) begin
          state_d    = StCheck;
          exp_rd_d   = 1'b1;
          exp_addr_d = '0;
        end
        wait_cnt_d = wait_cnt_q - LW'(1);
      end
      StCheck: begin
        // Reads run one cycle ahead of compares; the address wraps naturally at N.
        exp_addr_d = exp_addr_q + AW'(1);
        cmp_vld_d  = exp_rd_q;
        cmp_idx_d  = exp_addr_q;
        if (cmp_vld_q) begin
          if (mismatch) begin
            if (err_count_q != '1) err_count_d = err_count_q + CW'(1);
            if (!first_err_valid_q) begin
              first_err_valid_d = 1'b1;
              first_err_idx_d   = cmp_idx_q;
              first_err_frame_d = frame_cnt_q;
            end
          end
          if (cmp_idx_q == AW'(N - 1)) begin
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + CW'(1);
            pass_d      = (err_count_d == '0);
            cont_lat_d  = cont;
            if (!(cont_lat_q && cont)) begin
              state_d    = StIdle;
              busy_d     = 1'b0;
              exp_rd_d   = 1'b0;
              exp_addr_d = '0;
              cmp_vld_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= StIdle;
      wait_cnt_q        <= '0;
      cont_lat_q        <= 1'b0;
      exp_rd_q          <= 1'b0;
      exp_addr_q        <= '0;
      cmp_vld_q         <= 1'b0;
      cmp_idx_q         <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      err_count_q       <= '0;
      first_err_idx_q   <= '0;
      first_err_frame_q <= '0;
      first_err_valid_q <= 1'b0;
      frame_cnt_q       <= '0;
    end else begin
      state_q           <= state_d;
      wait_cnt_q        <= wait_cnt_d;
      cont_lat_q        <= cont_lat_d;
      exp_rd_q          <= exp_rd_d;
      exp_addr_q        <= exp_addr_d;
      cmp_vld_q         <= cmp_vld_d;
      cmp_idx_q         <= cmp_idx_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
      err_count_q       <= err_count_d;
      first_err_idx_q   <= first_err_idx_d;
      first_err_frame_q <= first_err_frame_d;
      first_err_valid_q <= first_err_valid_d;
      frame_cnt_q       <= frame_cnt_d;
    end
  end

  assign exp_rd          = exp_rd_q;
  assign exp_addr        = exp_addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign first_err_idx   = first_err_idx_q;
  assign first_err_frame = first_err_frame_q;
  assign first_err_valid = first_err_valid_q;
  assign frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_fft_stream_checker.sv
// Bench for fft_stream_checker: two instances (TOL=0 and TOL=1) share stimulus; a time-based
// model predicts every output each cycle, plus literal checks of the directed scenarios.
module tb_fft_stream_checker;
  localparam int DW  = 24;
  localparam int H   = 12;
  localparam int N   = 8;
  localparam int AW  = 3;
  localparam int LAT = 19;
  localparam int CW  = 16;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, cont = 1'b0;
  logic [DW-1:0] dut_out = '0;
  always #5 clk = ~clk;

  logic          exp_rd_s [2];
  logic [AW-1:0] exp_addr_s [2];
  logic [DW-1:0] exp_data_s [2];
  logic          busy_s [2], done_s [2], pass_s [2], fval_s [2];
  logic [CW-1:0] err_s [2], ffrm_s [2], fcnt_s [2];
  logic [AW-1:0] fidx_s [2];

  fft_stream_checker #(.DW(DW), .N(N), .LATENCY(LAT), .TOL(0), .CW(CW)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .dut_out(dut_out),
    .exp_rd(exp_rd_s[0]), .exp_addr(exp_addr_s[0]), .exp_data(exp_data_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err_s[0]),
    .first_err_idx(fidx_s[0]), .first_err_frame(ffrm_s[0]), .first_err_valid(fval_s[0]),
    .frame_cnt(fcnt_s[0]));

  fft_stream_checker #(.DW(DW), .N(N), .LATENCY(LAT), .TOL(1), .CW(CW)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .dut_out(dut_out),
    .exp_rd(exp_rd_s[1]), .exp_addr(exp_addr_s[1]), .exp_data(exp_data_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err_s[1]),
    .first_err_idx(fidx_s[1]), .first_err_frame(ffrm_s[1]), .first_err_valid(fval_s[1]),
    .frame_cnt(fcnt_s[1]));

  logic [DW-1:0] mem [N];
  int dre [4][N];
  int dim [4][N];

  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (exp_rd_s[i]) exp_data_s[i] <= mem[exp_addr_s[i]];

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit     in_run;
    longint e0;
    bit     cont_lat;
    int     err;
    int     fcnt;
    bit     fvalid;
    int     fidx;
    int     ffrm;
    bit     pass;
    bit     done;
    bit     e_rd;
    int     e_addr;
  } model_t;

  model_t md [2];
  int     tol_of [2] = '{0, 1};
  longint mt;

  function automatic int sx(input logic [H-1:0] v);
    return v[H-1] ? int'(v) - (1 << H) : int'(v);
  endfunction

  function automatic bit miss(input logic [DW-1:0] a, input logic [DW-1:0] b, input int tol);
    int dr, di;
    dr = sx(a[DW-1:H]) - sx(b[DW-1:H]);
    di = sx(a[H-1:0]) - sx(b[H-1:0]);
    if (dr < 0) dr = -dr;
    if (di < 0) di = -di;
    return (dr > tol) || (di > tol);
  endfunction

  task automatic model_step(input int i, input longint t);
    bit     was_idle;
    longint rel, d;
    int     k, f;
    was_idle   = !md[i].in_run;
    md[i].done = 1'b0;
    if (md[i].in_run) begin
      rel = t - md[i].e0 - LAT;
      if (rel >= 0) begin
        k = int'(rel % N);
        f = int'(rel / N);
        if (miss(dut_out, mem[k], tol_of[i])) begin
          if (md[i].err < 65535) md[i].err++;
          if (!md[i].fvalid) begin
            md[i].fvalid = 1'b1;
            md[i].fidx   = k;
            md[i].ffrm   = f;
          end
        end
        if (k == N - 1) begin
          md[i].fcnt++;
          md[i].done = 1'b1;
          md[i].pass = (md[i].err == 0);
          if (!(md[i].cont_lat && cont)) md[i].in_run = 1'b0;
          md[i].cont_lat = cont;
        end
      end
    end
    if (was_idle && start) begin
      md[i].in_run   = 1'b1;
      md[i].e0       = t;
      md[i].cont_lat = cont;
      md[i].err      = 0;
      md[i].fcnt     = 0;
      md[i].fvalid   = 1'b0;
      md[i].fidx     = 0;
      md[i].ffrm     = 0;
      md[i].pass     = 1'b0;
    end
    d = t - md[i].e0 - (LAT - 2);
    md[i].e_rd   = md[i].in_run && (d >= 0);
    md[i].e_addr = md[i].e_rd ? int'(d % N) : 0;
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      for (int i = 0; i < 2; i++) md[i] = '{default: 0};
    end else begin
      mt = cyc;
      for (int i = 0; i < 2; i++) model_step(i, mt);
    end
  end

  // ---------------- DUT stream driver ----------------
  initial forever begin
    longint rel;
    int k, f;
    logic [H-1:0] re, im;
    @(negedge clk);
    rel = cyc - md[0].e0 - LAT;
    if (md[0].in_run && rel >= 0) begin
      k  = int'(rel % N);
      f  = int'(rel / N);
      re = mem[k][DW-1:H];
      im = mem[k][H-1:0];
      if (f < 4) begin
        re = re + H'(dre[f][k]);
        im = im + H'(dim[f][k]);
      end
      dut_out = {re, im};
    end else begin
      dut_out = DW'($urandom);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d.exp_rd", i), 64'(exp_rd_s[i]), 64'(md[i].e_rd));
      chk($sformatf("d%0d.exp_addr", i), 64'(exp_addr_s[i]), 64'(md[i].e_addr));
      chk($sformatf("d%0d.busy", i), 64'(busy_s[i]), 64'(md[i].in_run));
      chk($sformatf("d%0d.done", i), 64'(done_s[i]), 64'(md[i].done));
      chk($sformatf("d%0d.pass", i), 64'(pass_s[i]), 64'(md[i].pass));
      chk($sformatf("d%0d.err_count", i), 64'(err_s[i]), 64'(md[i].err));
      chk($sformatf("d%0d.frame_cnt", i), 64'(fcnt_s[i]), 64'(md[i].fcnt));
      chk($sformatf("d%0d.first_err_valid", i), 64'(fval_s[i]), 64'(md[i].fvalid));
      chk($sformatf("d%0d.first_err_idx", i), 64'(fidx_s[i]), 64'(md[i].fidx));
      chk($sformatf("d%0d.first_err_frame", i), 64'(ffrm_s[i]), 64'(md[i].ffrm));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_corr();
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < N; k++) begin
        dre[f][k] = 0;
        dim[f][k] = 0;
      end
  endtask

  task automatic do_start(input bit c, output longint e0);
    start = 1'b1;
    cont  = c;
    e0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input longint c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done(output longint de);
    int n;
    n = 0;
    @(negedge clk);
    while (!done_s[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done_s[0]) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within 200 cycles, want a done pulse");
      de = -1;
    end else begin
      de = cyc - 1;
    end
  endtask

  longint e0, e1, de, d1, d2, d3;

  initial begin
    mem[0] = 24'h000_000;
    mem[1] = 24'h001_FFF;
    mem[2] = 24'h100_800;
    mem[3] = 24'h123_456;
    mem[4] = 24'hABC_DEF;
    mem[5] = 24'hFFF_001;
    mem[6] = 24'h400_C00;
    mem[7] = 24'h800_7FF;
    clear_corr();

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_s[0]), 0);
    chk("rst_exp_rd", 64'(exp_rd_s[0]), 0);
    chk("rst_pass", 64'(pass_s[0]), 0);
    reset = 1'b1;
    @(negedge clk);

    // Clean frame: read timing and done latency.
    do_start(1'b0, e0);
    wait_until(e0 + 17);
    chk("t1_rd_before", 64'(exp_rd_s[0]), 0);
    @(negedge clk);
    chk("t1_rd_first", 64'(exp_rd_s[0]), 1);
    chk("t1_addr_first", 64'(exp_addr_s[0]), 0);
    wait_done(de);
    chk("t1_done_edge", 64'(de - e0), 26);
    chk("t1_err", 64'(err_s[0]), 0);
    chk("t1_pass", 64'(pass_s[0]), 1);
    chk("t1_fcnt", 64'(fcnt_s[0]), 1);
    chk("t1_busy", 64'(busy_s[0]), 0);
    repeat (2) @(negedge clk);

    // Two corrupted samples.
    dim[0][3] = 1;
    dre[0][6] = -5;
    do_start(1'b0, e0);
    wait_done(de);
    chk("t2_err", 64'(err_s[0]), 2);
    chk("t2_fidx", 64'(fidx_s[0]), 3);
    chk("t2_ffrm", 64'(ffrm_s[0]), 0);
    chk("t2_fval", 64'(fval_s[0]), 1);
    chk("t2_pass", 64'(pass_s[0]), 0);
    repeat (2) @(negedge clk);

    // Tolerance: +1 ok, -2 not, 0x7FF vs 0x800 not.
    clear_corr();
    dre[0][2] = 1;
    dim[0][5] = -2;
    dre[0][7] = -1;
    do_start(1'b0, e0);
    wait_done(de);
    chk("t3_tol1_err", 64'(err_s[1]), 2);
    chk("t3_tol1_fidx", 64'(fidx_s[1]), 5);
    chk("t3_tol0_err", 64'(err_s[0]), 3);
    chk("t3_tol0_fidx", 64'(fidx_s[0]), 2);
    repeat (2) @(negedge clk);

    // Continuous mode, three frames, error in frame 1 at k=4.
    clear_corr();
    dre[1][4] = 3;
    do_start(1'b1, e0);
    wait_until(e0 + 25);
    chk("t4_addr_last", 64'(exp_addr_s[0]), 7);
    @(negedge clk);
    chk("t4_addr_wrap", 64'(exp_addr_s[0]), 0);
    chk("t4_rd_wrap", 64'(exp_rd_s[0]), 1);
    wait_done(d1);
    wait_done(d2);
    cont = 1'b0;
    wait_done(d3);
    chk("t4_done1", 64'(d1 - e0), 26);
    chk("t4_gap12", 64'(d2 - d1), 8);
    chk("t4_gap23", 64'(d3 - d2), 8);
    chk("t4_fcnt", 64'(fcnt_s[0]), 3);
    chk("t4_err", 64'(err_s[0]), 1);
    chk("t4_ffrm", 64'(ffrm_s[0]), 1);
    chk("t4_fidx", 64'(fidx_s[0]), 4);
    chk("t4_busy", 64'(busy_s[0]), 0);
    repeat (2) @(negedge clk);

    // Asynchronous abort mid-check.
    clear_corr();
    dre[0][2] = 2;
    do_start(1'b0, e0);
    wait_until(e0 + 25);
    chk("t5_err_pre", 64'(err_s[0]), 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_busy", 64'(busy_s[0]), 0);
    chk("t5_rd", 64'(exp_rd_s[0]), 0);
    chk("t5_addr", 64'(exp_addr_s[0]), 0);
    chk("t5_err", 64'(err_s[0]), 0);
    chk("t5_fval", 64'(fval_s[0]), 0);
    chk("t5_fidx", 64'(fidx_s[0]), 0);
    @(negedge clk);
    reset = 1'b1;
    clear_corr();
    @(negedge clk);
    do_start(1'b0, e0);
    wait_done(de);
    chk("t5_rerun_err", 64'(err_s[0]), 0);
    chk("t5_rerun_pass", 64'(pass_s[0]), 1);
    chk("t5_rerun_fcnt", 64'(fcnt_s[0]), 1);
    repeat (2) @(negedge clk);

    // Ignored starts while busy, then a start in the done cycle.
    dre[0][1] = 4;
    do_start(1'b0, e0);
    wait_until(e0 + 5);
    pulse_start();
    wait_until(e0 + 22);
    pulse_start();
    wait_done(de);
    chk("t6_done_edge", 64'(de - e0), 26);
    chk("t6_err", 64'(err_s[0]), 1);
    clear_corr();
    do_start(1'b0, e1);
    chk("t6_new_err", 64'(err_s[0]), 0);
    chk("t6_new_fval", 64'(fval_s[0]), 0);
    chk("t6_new_busy", 64'(busy_s[0]), 1);
    chk("t6_new_e0", 64'(e1 - de), 1);
    wait_done(de);
    chk("t6_new_done_edge", 64'(de - e1), 26);
    chk("t6_new_pass", 64'(pass_s[0]), 1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish before 200000");
    $fatal(1);
  end

endmodule
